// File: rtl/mul_shift_acc_if.sv
// Operand/result bundle for the 16x16 shift-add multiplier.
interface mul_shift_acc_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul_shift_acc.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial product per clock.
// Optional early termination once the multiplier is exhausted: MUL_SHIFT_ACC_EARLY_EXIT_EN.
module mul_shift_acc (
  input  logic                 clk,
  input  logic                 rst,
  mul_shift_acc_if.slave       bus
);

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned STEPS  = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [PROD_W-1:0]   mcand, mcand_nxt;
  logic [OP_W-1:0]     mplier, mplier_nxt;
  logic [PROD_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                busy_r, busy_nxt;
  logic                done_r, done_nxt;
  logic [PROD_W-1:0]   product_r, product_nxt;
  logic                term_c;

  // Operation ends after all steps, or as soon as no multiplier bits remain.
`ifdef MUL_SHIFT_ACC_EARLY_EXIT_EN
  assign term_c = (cnt == CNT_W'(STEPS)) || (mplier == OP_W'(0));
`else
  assign term_c = (cnt == CNT_W'(STEPS));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (term_c)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    product_nxt = product_r;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt  = {16'h0, bus.a};
          mplier_nxt = bus.b;
          acc_nxt    = PROD_W'(0);
          cnt_nxt    = CNT_W'(0);
          busy_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (term_c) begin
          product_nxt = acc;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
        end else begin
          acc_nxt    = acc + (mplier[0] ? mcand : PROD_W'(0));
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          cnt_nxt    = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= PROD_W'(0);
      mplier    <= OP_W'(0);
      acc       <= PROD_W'(0);
      cnt       <= CNT_W'(0);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= PROD_W'(0);
    end else begin
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      product_r <= product_nxt;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_mul_shift_acc.sv
// Self-checking bench for mul_shift_acc: transaction-level model plus directed literal checks.
module tb_mul_shift_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mul_shift_acc_if bus ();

  mul_shift_acc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: whole-operation view (latency countdown and a*b result)
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_product = 32'd0;
  logic [31:0] m_pend = 32'd0;
  int          m_left = 0;

  function automatic int lat(input logic [15:0] bv);
`ifdef MUL_SHIFT_ACC_EARLY_EXIT_EN
    if (bv == 16'd0) return 1;
    for (int i = 15; i >= 0; i--) if (bv[i]) return i + 2;
    return 1;
`else
    return 17;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_product = 32'd0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_product = m_pend;
        end
      end else if (bus.start) begin
        m_busy = 1'b1;
        m_pend = 32'(bus.a) * 32'(bus.b);
        m_left = lat(bus.b);
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("product", bus.product, m_product);
    end
  end

  // Issue one operation from the current negedge and wait (bounded) for done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [31:0] ep, input int elat, input string nm);
    int k;
    bus.start = 1'b1; bus.a = ta; bus.b = tbv;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'(elat));
    chk({nm, "_product"}, bus.product, ep);
  endtask

  initial begin
    bus.start = 1'b0; bus.a = 16'd0; bus.b = 16'd0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", bus.product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17, "ffff_ffff");
    @(negedge clk);
`ifdef MUL_SHIFT_ACC_EARLY_EXIT_EN
    run_op(16'd3, 16'd5, 32'd15, 4, "3x5");
    @(negedge clk);
    run_op(16'h1234, 16'h0000, 32'd0, 1, "b_zero");
`else
    run_op(16'd3, 16'd5, 32'd15, 17, "3x5");
    @(negedge clk);
    run_op(16'h1234, 16'h0000, 32'd0, 17, "b_zero");
`endif
    @(negedge clk);
    run_op(16'h0002, 16'h8000, 32'h00010000, 17, "b_msb");
    // Back-to-back: start presented in the done cycle
    run_op(16'd100, 16'd200, 32'd20000, lat(16'd200), "b2b");
    @(negedge clk);

    // Start while busy is ignored
    bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd1; bus.b = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int k; int pulses;
      k = 5; pulses = 0;
      while (k < 40) begin
        if (bus.done) begin
          pulses++;
          if (pulses == 1) begin
            chk("ignore_latency", 32'(k), 32'(lat(16'd9)));
            chk("ignore_product", bus.product, 32'd63);
          end
        end
        @(negedge clk);
        k++;
      end
      chk("ignore_pulses", 32'(pulses), 32'd1);
    end

    // Reset pulsed mid-run
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", bus.product, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op(16'd2, 16'd2, 32'd4, lat(16'd2), "after_reset");
    @(negedge clk);

    // A few extra patterns through the model
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom); rb = 16'($urandom) >> (4 * i);
      run_op(ra, rb, 32'(ra) * 32'(rb), lat(rb), "rand");
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
